// File: rtl/csr_pkg.sv
// Shared CSR definitions: operation encoding, CSR addresses, privilege levels,
// trap/interrupt codes, mip/mstatus bit positions and the register bundle type.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'd1,
    CSR_RS = 2'd2,
    CSR_RC = 2'd3
  } csr_op_t;

  localparam logic [1:0] USER_MODE       = 2'b00;
  localparam logic [1:0] SUPERVISOR_MODE = 2'b01;
  localparam logic [1:0] MACHINE_MODE    = 2'b11;

  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;
  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

  localparam logic [62:0] INSTR_ILLEGAL = 63'd2;
  localparam logic [62:0] ECALL_M       = 63'd11;
  localparam logic [62:0] M_SWINT       = 63'd3;
  localparam logic [62:0] M_TRINT       = 63'd7;
  localparam logic [62:0] M_EXINT       = 63'd11;

  typedef struct packed {
    logic        st_mie;
    logic        st_mpie;
    logic [1:0]  st_mpp;
    logic [1:0]  priv;
    logic [63:0] mie;
    logic [63:0] mip;
    logic [63:0] mtvec;
    logic [63:0] mscratch;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic [63:0] mcycle;
  } csr_regs_t;

  // 2'b10 is a reserved privilege encoding; it collapses to USER.
  function automatic logic [1:0] legal_mpp(input logic [1:0] v);
    return (v == 2'b10) ? USER_MODE : v;
  endfunction

endpackage

// File: rtl/csr_irq_sel.sv
// Machine interrupt selector: enabled-and-pending sources to a single request
// with fixed priority external > software > timer.
module csr_irq_sel
  import csr_pkg::*;
(
  input  logic        global_ie_i,
  input  logic        sw_i,
  input  logic        tm_i,
  input  logic        ext_i,
  output logic        irq_pending_o,
  output logic [62:0] irq_cause_o
);

  // Priority encode the enabled sources.
  always_comb begin
    irq_pending_o = global_ie_i & (sw_i | tm_i | ext_i);
    if (ext_i)      irq_cause_o = M_EXINT;
    else if (sw_i)  irq_cause_o = M_SWINT;
    else if (tm_i)  irq_cause_o = M_TRINT;
    else            irq_cause_o = '0;
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file at writeback: CSR read/modify/write, trap entry, mret,
// mcycle and interrupt request generation.
// Build option: CSR_MTVEC_VECTORED_EN makes mtvec.mode writable and sends
// interrupts to base + 4*code when mode is vectored.
module csr_file
  import csr_pkg::*;
#(
  parameter int          HART_ID   = 0,
  parameter logic [63:0] RST_MTVEC = 64'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        csr_valid_i,
  input  csr_op_t     csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  output logic [63:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_valid_i,
  input  logic [62:0] trap_cause_i,
  input  logic [63:0] trap_pc_i,
  input  logic [63:0] trap_tval_i,
  input  logic        mret_valid_i,
  input  logic        irq_sw_i,
  input  logic        irq_tm_i,
  input  logic        irq_ext_i,
  output logic        irq_pending_o,
  input  logic        irq_take_i,
  output logic [62:0] irq_cause_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic [1:0]  priv_mode_o
);

  csr_regs_t   regs_q, regs_d;
  logic [63:0] mstatus_w;
  logic [63:0] new_val;
  logic [63:0] mtvec_base;
  logic        wr_en;

  assign mstatus_w = ({51'b0, regs_q.st_mpp, 3'b0, regs_q.st_mpie, 3'b0, regs_q.st_mie, 3'b0})
                     & MSTATUS_WMASK;
  assign mtvec_base  = {regs_q.mtvec[63:2], 2'b00};
  assign priv_mode_o = regs_q.priv;

  csr_irq_sel u_irq_sel (
    .global_ie_i   (regs_q.st_mie),
    .sw_i          (regs_q.mie[MIP_MSIP] & regs_q.mip[MIP_MSIP]),
    .tm_i          (regs_q.mie[MIP_MTIP] & regs_q.mip[MIP_MTIP]),
    .ext_i         (regs_q.mie[MIP_MEIP] & regs_q.mip[MIP_MEIP]),
    .irq_pending_o (irq_pending_o),
    .irq_cause_o   (irq_cause_o)
  );

  // Combinational read port and address decode.
  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_addr_i)
      CSR_SATP:     csr_rdata_o = '0;
      CSR_MSTATUS:  csr_rdata_o = mstatus_w;
      CSR_MIE:      csr_rdata_o = regs_q.mie;
      CSR_MTVEC:    csr_rdata_o = regs_q.mtvec;
      CSR_MSCRATCH: csr_rdata_o = regs_q.mscratch;
      CSR_MEPC:     csr_rdata_o = regs_q.mepc;
      CSR_MCAUSE:   csr_rdata_o = regs_q.mcause;
      CSR_MTVAL:    csr_rdata_o = regs_q.mtval;
      CSR_MIP:      csr_rdata_o = regs_q.mip;
      CSR_MCYCLE:   csr_rdata_o = regs_q.mcycle;
      CSR_MHARTID:  csr_rdata_o = 64'(HART_ID);
      default:      csr_illegal_o = 1'b1;
    endcase
  end

  // Read-modify-write value; set/clear with zero operand never writes.
  always_comb begin
    case (csr_op_i)
      CSR_RS:  new_val = csr_rdata_o | csr_wdata_i;
      CSR_RC:  new_val = csr_rdata_o & ~csr_wdata_i;
      default: new_val = csr_wdata_i;
    endcase
    wr_en = csr_valid_i & ~csr_illegal_o & ~trap_valid_i & ~mret_valid_i
            & ((csr_op_i == CSR_RW) | (csr_wdata_i != '0));
  end

  // Fetch redirect: trap wins over mret; reset suppresses both.
  always_comb begin
    redirect_valid_o = (trap_valid_i | mret_valid_i) & ~reset_i;
    redirect_pc_o    = mtvec_base;
    if (!trap_valid_i && mret_valid_i) begin
      redirect_pc_o = regs_q.mepc;
    end
`ifdef CSR_MTVEC_VECTORED_EN
    else if (trap_valid_i && irq_take_i && regs_q.mtvec[1:0] == 2'b01) begin
      redirect_pc_o = mtvec_base + {1'b0, irq_cause_o[60:0], 2'b00};
    end
`endif
  end

  // Next-state: trap > mret > CSR write; mcycle ticks unless written.
  always_comb begin
    regs_d               = regs_q;
    regs_d.mcycle        = regs_q.mcycle + 64'd1;
    regs_d.mip           = '0;
    regs_d.mip[MIP_MSIP] = irq_sw_i;
    regs_d.mip[MIP_MTIP] = irq_tm_i;
    regs_d.mip[MIP_MEIP] = irq_ext_i;
    if (trap_valid_i) begin
      regs_d.mepc    = trap_pc_i;
      regs_d.mcause  = irq_take_i ? {1'b1, irq_cause_o} : {1'b0, trap_cause_i};
      regs_d.mtval   = irq_take_i ? 64'd0 : trap_tval_i;
      regs_d.st_mpie = regs_q.st_mie;
      regs_d.st_mie  = 1'b0;
      regs_d.st_mpp  = regs_q.priv;
      regs_d.priv    = MACHINE_MODE;
    end else if (mret_valid_i) begin
      regs_d.st_mie  = regs_q.st_mpie;
      regs_d.st_mpie = 1'b1;
      regs_d.priv    = regs_q.st_mpp;
      regs_d.st_mpp  = USER_MODE;
    end else if (wr_en) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          regs_d.st_mie  = new_val[MSTATUS_MIE];
          regs_d.st_mpie = new_val[MSTATUS_MPIE];
          regs_d.st_mpp  = legal_mpp(new_val[MSTATUS_MPP+1:MSTATUS_MPP]);
        end
        CSR_MIE:      regs_d.mie      = new_val;
`ifdef CSR_MTVEC_VECTORED_EN
        CSR_MTVEC:    regs_d.mtvec    = {new_val[63:2], (new_val[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
        CSR_MTVEC:    regs_d.mtvec    = {new_val[63:2], 2'b00};
`endif
        CSR_MSCRATCH: regs_d.mscratch = new_val;
        CSR_MEPC:     regs_d.mepc     = {new_val[63:2], 2'b00};
        CSR_MCAUSE:   regs_d.mcause   = new_val;
        CSR_MTVAL:    regs_d.mtval    = new_val;
        CSR_MCYCLE:   regs_d.mcycle   = new_val;
        default: ;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q      <= '0;
`ifdef CSR_MTVEC_VECTORED_EN
      regs_q.mtvec <= {RST_MTVEC[63:2], (RST_MTVEC[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
      regs_q.mtvec <= {RST_MTVEC[63:2], 2'b00};
`endif
      regs_q.priv <= MACHINE_MODE;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus pushes expected values tagged with
// the cycle they apply to; a monitor samples on the falling edge and compares.
module tb_csr_file;
  import csr_pkg::*;

  localparam int SEL_RDATA = 0, SEL_ILL = 1, SEL_RVALID = 2, SEL_RPC = 3,
                 SEL_PEND = 4, SEL_CAUSE = 5, SEL_PRIV = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_valid = 1'b0;
  csr_op_t     csr_op = CSR_RW;
  logic [11:0] csr_addr = CSR_MTVEC;
  logic [63:0] csr_wdata = '0;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid = 1'b0;
  logic [62:0] trap_cause = '0;
  logic [63:0] trap_pc = '0;
  logic [63:0] trap_tval = '0;
  logic        mret_valid = 1'b0;
  logic        irq_sw = 1'b0, irq_tm = 1'b0, irq_ext = 1'b0;
  logic        irq_pending;
  logic        irq_take = 1'b0;
  logic [62:0] irq_cause;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  priv_mode;

  csr_file #(.HART_ID(0), .RST_MTVEC(64'h0)) dut (
    .clk_i(clk), .reset_i(reset),
    .csr_valid_i(csr_valid), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .trap_valid_i(trap_valid), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
    .trap_tval_i(trap_tval), .mret_valid_i(mret_valid),
    .irq_sw_i(irq_sw), .irq_tm_i(irq_tm), .irq_ext_i(irq_ext),
    .irq_pending_o(irq_pending), .irq_take_i(irq_take), .irq_cause_o(irq_cause),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .priv_mode_o(priv_mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_RDATA:  return csr_rdata;
      SEL_ILL:    return 64'(csr_illegal);
      SEL_RVALID: return 64'(redirect_valid);
      SEL_RPC:    return redirect_pc;
      SEL_PEND:   return 64'(irq_pending);
      SEL_CAUSE:  return 64'(irq_cause);
      default:    return 64'(priv_mode);
    endcase
  endfunction

  // Monitor: retire every expectation due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [63:0] act;
      e   = exp_q.pop_front();
      act = observe(e.sel);
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s: actual=%h required=%h (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc, e.cyc);
      end
    end
  end

  task automatic expect_v(input int sel, input logic [63:0] v, input string name);
    exp_q.push_back('{cyc, sel, v, name});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input csr_op_t op, input logic [11:0] a, input logic [63:0] d);
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    tick();
    csr_valid = 1'b0;
  endtask

  task automatic rd_chk(input logic [11:0] a, input logic [63:0] v, input string name);
    csr_addr = a;
    expect_v(SEL_RDATA, v, name);
    tick();
  endtask

  task automatic trap(input logic [62:0] cause, input logic [63:0] pc,
                      input logic [63:0] tval, input logic take,
                      input logic [63:0] exp_pc, input string name);
    trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval; irq_take = take;
    expect_v(SEL_RVALID, 64'd1, {name, "_rvalid"});
    expect_v(SEL_RPC, exp_pc, {name, "_rpc"});
    tick();
    trap_valid = 1'b0; irq_take = 1'b0;
  endtask

  localparam logic [63:0] BASE = 64'h8000_0100;
`ifdef CSR_MTVEC_VECTORED_EN
  localparam logic [63:0] MTVEC_VEC_RD = 64'h8000_0101;
  localparam logic [63:0] VEC_EXT_PC   = 64'h8000_012C;
`else
  localparam logic [63:0] MTVEC_VEC_RD = 64'h8000_0100;
  localparam logic [63:0] VEC_EXT_PC   = 64'h8000_0100;
`endif

  initial begin
    // Reset: first edge loads reset values; trap/mret while in reset must not redirect.
    tick();
    trap_valid = 1'b1; mret_valid = 1'b1; trap_pc = 64'h44; csr_addr = 12'h7C0;
    expect_v(SEL_RVALID, 64'd0, "reset_redirect");
    expect_v(SEL_PEND, 64'd0, "reset_pending");
    expect_v(SEL_PRIV, 64'd3, "reset_priv");
    expect_v(SEL_ILL, 64'd1, "illegal_addr");
    tick();
    trap_valid = 1'b0; mret_valid = 1'b0; reset = 1'b0;
    csr_addr = CSR_MTVEC;
    expect_v(SEL_ILL, 64'd0, "legal_addr");
    rd_chk(CSR_MEPC, 64'd0, "reset_mepc");
    rd_chk(CSR_MTVEC, 64'd0, "reset_mtvec");

    // CSRRW / CSRRS / CSRRC.
    wr(CSR_RW, CSR_MTVEC, 64'h8000_0100);
    rd_chk(CSR_MTVEC, BASE, "rw_mtvec");
    wr(CSR_RW, CSR_MSCRATCH, 64'h0F);
    csr_valid = 1'b1; csr_op = CSR_RS; csr_addr = CSR_MSCRATCH; csr_wdata = 64'hF0;
    expect_v(SEL_RDATA, 64'h0F, "rs_old_value");
    tick();
    csr_valid = 1'b0;
    rd_chk(CSR_MSCRATCH, 64'hFF, "rs_mscratch");
    wr(CSR_RC, CSR_MSCRATCH, 64'h0F);
    rd_chk(CSR_MSCRATCH, 64'hF0, "rc_mscratch");

    // mstatus write mask and reserved mpp.
    wr(CSR_RW, CSR_MSTATUS, 64'hFFFF_0000_0000_1008);
    rd_chk(CSR_MSTATUS, 64'h8, "mstatus_mask_mpp");

    // ECALL_M trap.
    trap(ECALL_M, 64'h8000_0010, 64'h1234, 1'b0, BASE, "ecall");
    rd_chk(CSR_MEPC, 64'h8000_0010, "ecall_mepc");
    rd_chk(CSR_MCAUSE, 64'hB, "ecall_mcause");
    rd_chk(CSR_MTVAL, 64'h1234, "ecall_mtval");
    rd_chk(CSR_MSTATUS, 64'h1880, "ecall_mstatus");

    // mret to USER.
    wr(CSR_RW, CSR_MEPC, 64'h8000_0016);
    rd_chk(CSR_MEPC, 64'h8000_0014, "mepc_align");
    wr(CSR_RW, CSR_MSTATUS, 64'h80);
    mret_valid = 1'b1;
    expect_v(SEL_RVALID, 64'd1, "mret_rvalid");
    expect_v(SEL_RPC, 64'h8000_0014, "mret_rpc");
    tick();
    mret_valid = 1'b0;
    expect_v(SEL_PRIV, 64'd0, "mret_priv");
    rd_chk(CSR_MSTATUS, 64'h88, "mret_mstatus");

    // Timer interrupt.
    irq_tm = 1'b1;
    wr(CSR_RW, CSR_MIE, 64'h80);
    expect_v(SEL_PEND, 64'd1, "tm_pending");
    expect_v(SEL_CAUSE, 64'd7, "tm_cause");
    rd_chk(CSR_MIP, 64'h80, "tm_mip");
    trap(M_TRINT, 64'h8000_0020, 64'h55, 1'b1, BASE, "tm_take");
    irq_tm = 1'b0;
    expect_v(SEL_PRIV, 64'd3, "tm_priv");
    expect_v(SEL_PEND, 64'd0, "tm_masked");
    rd_chk(CSR_MCAUSE, 64'h8000_0000_0000_0007, "tm_mcause");
    rd_chk(CSR_MTVAL, 64'd0, "tm_mtval");
    rd_chk(CSR_MSTATUS, 64'h80, "tm_mstatus");

    // Software + external pending; external wins.
    irq_sw = 1'b1; irq_ext = 1'b1;
    wr(CSR_RW, CSR_MTVEC, 64'h8000_0101);
    wr(CSR_RW, CSR_MIE, 64'h888);
    wr(CSR_RW, CSR_MSTATUS, 64'h8);
    expect_v(SEL_PEND, 64'd1, "ext_pending");
    expect_v(SEL_CAUSE, 64'hB, "ext_cause");
    rd_chk(CSR_MTVEC, MTVEC_VEC_RD, "mtvec_mode");
    trap(M_EXINT, 64'h8000_0030, 64'h0, 1'b1, VEC_EXT_PC, "ext_take");
    irq_sw = 1'b0; irq_ext = 1'b0;
    rd_chk(CSR_MCAUSE, 64'h8000_0000_0000_000B, "ext_mcause");

    // mcycle write then increment.
    wr(CSR_RW, CSR_MCYCLE, 64'd5);
    rd_chk(CSR_MCYCLE, 64'd5, "mcycle_write");
    rd_chk(CSR_MCYCLE, 64'd6, "mcycle_inc");

    // Read-only / hardwired registers.
    rd_chk(CSR_MHARTID, 64'd0, "mhartid");
    wr(CSR_RW, CSR_SATP, 64'h1234);
    rd_chk(CSR_SATP, 64'd0, "satp_zero");
    wr(CSR_RW, CSR_MIP, 64'hFFF);
    rd_chk(CSR_MIP, 64'd0, "mip_readonly");

    // trap + mret + CSR write together: only the trap lands.
    csr_valid = 1'b1; csr_op = CSR_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 64'hDEAD;
    mret_valid = 1'b1;
    trap(INSTR_ILLEGAL, 64'h8000_0040, 64'h0, 1'b0, BASE, "collide");
    csr_valid = 1'b0; mret_valid = 1'b0;
    expect_v(SEL_PRIV, 64'd3, "collide_priv");
    rd_chk(CSR_MSCRATCH, 64'hF0, "collide_mscratch");
    rd_chk(CSR_MEPC, 64'h8000_0040, "collide_mepc");
    rd_chk(CSR_MCAUSE, 64'd2, "collide_mcause");

    // Reset asserted during a trap.
    reset = 1'b1; trap_valid = 1'b1; trap_pc = 64'h98;
    expect_v(SEL_RVALID, 64'd0, "reset_mid_trap");
    tick();
    reset = 1'b0; trap_valid = 1'b0;
    rd_chk(CSR_MEPC, 64'd0, "reset_mid_mepc");
    rd_chk(CSR_MTVEC, 64'd0, "reset_mid_mtvec");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
